spi_flash_burst: RTL and testbench
==================================

// Module: spi_flash_burst
// PURPOSE
//  SPI (mode 0) NOR-flash burst reader: one request fetches REQ_LEN consecutive 32-bit words
//  with a single command + address phase, streaming each word out as it completes.
//  Generalises the single-word fetch path: programmable SCK divider, optional FAST_READ (0x0B + dummy).
//  Configurable address width. Internally generated, registered SCK.
//  Sits between the instruction/data fetch arbiter and the flash pins.
// PARAMETERS
//  ADDR_BITS      24  flash byte-address width sent on the wire (24 or 32); word address = ADDR_BITS-2 bits
//  CLK_DIV        1   SCK half-period in clk cycles (>=1); f_SCK = f_clk/(2*CLK_DIV)
//  FAST_READ      0   0: cmd 0x03, no dummy; 1: cmd 0x0B + 8 dummy bits
//  MAX_LEN        8   max words per burst; LEN_W = $clog2(MAX_LEN+1)
//  CS_HIGH_CYC    2   min clk cycles cs_n held high between bursts
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            asynchronous active-low reset
//  req_valid      in   1            burst request
//  req_ready      out  1            high only in IDLE; transfer on req_valid&&req_ready
//  req_word_addr  in   ADDR_BITS-2  start word address; byte addr = {req_word_addr,2'b00}
//  req_len        in   LEN_W        words to fetch; 0 treated as 1, >MAX_LEN clamped to MAX_LEN
//  rd_valid       out  1            one-cycle pulse per completed word (no backpressure)
//  rd_data        out  32           word, first byte received in [7:0] (little-endian)
//  rd_last        out  1            qualifies rd_valid for final word of burst
//  busy           out  1            high from request accept until IDLE re-entered (incl. GAP)
//  spi_clk        out  1            SCK, registered, idle low
//  spi_cs_n       out  1            chip select, active low
//  spi_mosi       out  1            MSB-first command/address
//  spi_miso       in   1            flash data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, rd_valid=0, rd_last=0,
//   rd_data=0, busy=0, req_ready=1; all counters cleared. Burst in flight is abandoned, no rd_valid.
//  FSM: IDLE -> CMD(8b) -> ADDR(ADDR_BITS b) -> [DUMMY(8b) if FAST_READ] -> DATA(32*len b) -> GAP -> IDLE.
//  Header bits H = 8+ADDR_BITS+(FAST_READ?8:0). Accept edge E0: latch addr/len, spi_cs_n=0,
//   spi_mosi = cmd[7], spi_clk=0.
//  Bit k (0-based, over header+data): SCK rises at edge E0+CLK_DIV*(2k+1), falls at E0+CLK_DIV*(2k+2).
//   MOSI updates only on SCK falling edges; MISO sampled on the clk edge that raises SCK.
//   MOSI=0 during DUMMY and DATA.
//  Word j complete at sample of bit H+32j+31; rd_valid/rd_data/rd_last registered on that edge
//   (visible the following cycle), rd_last=1 iff j=len-1. rd_data holds until next word.
//  After final SCK fall (E0+2*CLK_DIV*(H+32*len)) spi_cs_n=1 same edge; GAP lasts CS_HIGH_CYC cycles,
//   then IDLE. SCK never pulses with cs_n high.
//  req_valid outside IDLE ignored (not queued). Address increment across burst is done by the flash;
//   block does not wrap or check the address.
//  Divider counter is reset on accept so every burst starts phase-aligned.
// TESTING
//  1 Reset: assert rst_n=0 mid-ADDR -> cs_n=1, spi_clk=0, rd_valid=0, req_ready=1 within the same cycle.
//  2 Single word, CLK_DIV=1, FAST_READ=0, addr 0x40 (byte 0x000100), flash bytes 11 22 33 44 ->
//    MOSI shows 0x03,0x00,0x01,0x00; one rd_valid with rd_last=1, rd_data=0x44332211, at edge E0+127.
//  3 Burst len=4 from byte 0x000000, model holds 0x00..0x0F -> four rd_valid pulses 64 clk apart:
//    0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; rd_last only on 4th; exactly 32+128 SCK pulses.
//  4 CLK_DIV=3, FAST_READ=1 -> MOSI 0x0B + addr + 8 zero bits; SCK period 6 clk; data correct.
//  5 req_len=0 -> 1 word; req_len=15 with MAX_LEN=8 -> 8 words; req_valid while busy -> ignored.
//  6 Back-to-back requests -> cs_n high >= CS_HIGH_CYC cycles between bursts; no SCK edge while cs_n=1.

Source files
------------

// File: rtl/spi_flash_burst.sv
// rtl/spi_flash_burst.sv - SPI mode-0 NOR-flash burst reader (single command/address, N words)
module spi_flash_burst #(
  parameter int ADDR_BITS   = 24,
  parameter int CLK_DIV     = 1,
  parameter bit FAST_READ   = 1'b0,
  parameter int MAX_LEN     = 8,
  parameter int CS_HIGH_CYC = 2,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-3:0] req_word_addr,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 spi_clk,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int SR_W  = 16 + ADDR_BITS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
  localparam logic [7:0] CMD = FAST_READ ? 8'h0B : 8'h03;

  typedef enum logic [2:0] {IDLE, CMD_S, ADDR_S, DUMMY_S, DATA_S, GAP_S} state_t;
  state_t state_q, state_d;

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [LEN_W-1:0] word_cnt, len_m1;
  logic [GAP_W-1:0] gap_cnt;
  logic [SR_W-2:0]  tx_sr;
  logic [30:0]      rx_sr;
  logic shifting, tick, sck_rise, sck_fall, phase_end, accept, word_end;

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;
  assign shifting  = state_q inside {CMD_S, ADDR_S, DUMMY_S, DATA_S};
  assign tick      = shifting && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise  = tick && !spi_clk;
  assign sck_fall  = tick && spi_clk;
  assign word_end  = (state_q == DATA_S) && (bit_cnt == 6'd31);

  // Phases advance on the SCK falling edge that closes their last bit.
  always_comb begin
    state_d   = state_q;
    phase_end = 1'b0;
    case (state_q)
      IDLE:    if (req_valid) state_d = CMD_S;
      CMD_S: begin
        phase_end = sck_fall && (bit_cnt == 6'd7);
        if (phase_end) state_d = ADDR_S;
      end
      ADDR_S: begin
        phase_end = sck_fall && (bit_cnt == 6'(ADDR_BITS - 1));
        if (phase_end) state_d = FAST_READ ? DUMMY_S : DATA_S;
      end
      DUMMY_S: begin
        phase_end = sck_fall && (bit_cnt == 6'd7);
        if (phase_end) state_d = DATA_S;
      end
      DATA_S: begin
        phase_end = sck_fall && word_end && (word_cnt == len_m1);
        if (phase_end) state_d = GAP_S;
      end
      GAP_S:   if (gap_cnt == GAP_W'(CS_HIGH_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      len_m1   <= '0;
      gap_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      if (accept) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        gap_cnt  <= '0;
        spi_clk  <= 1'b0;
        spi_cs_n <= 1'b0;
        spi_mosi <= CMD[7];
        tx_sr    <= {CMD[6:0], req_word_addr, 2'b00, 8'h00};
        len_m1   <= (req_len == '0) ? '0 :
                    (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN - 1) : req_len - LEN_W'(1);
      end else if (shifting) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) spi_clk <= !spi_clk;
        if (sck_rise) begin
          rx_sr <= {rx_sr[29:0], spi_miso};
          // Bytes arrive MSB-first; the first byte of each word lands in [7:0].
          if (word_end) begin
            rd_valid <= 1'b1;
            rd_last  <= (word_cnt == len_m1);
            rd_data  <= {rx_sr[6:0], spi_miso, rx_sr[14:7], rx_sr[22:15], rx_sr[30:23]};
          end
        end
        if (sck_fall) begin
          tx_sr    <= tx_sr << 1;
          spi_mosi <= tx_sr[SR_W-2];
          bit_cnt  <= (phase_end || word_end) ? '0 : bit_cnt + 6'd1;
          if (word_end) word_cnt <= word_cnt + LEN_W'(1);
          if (state_q == DATA_S && phase_end) spi_cs_n <= 1'b1;
        end
      end else if (state_q == GAP_S) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_burst.sv
// tb/tb_spi_flash_burst.sv - directed bench for spi_flash_burst with a behavioural flash model
module tb_spi_flash_burst;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, rd_valid, rd_last, busy, spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic [21:0] req_word_addr [2];
  logic [3:0]  req_len [2];
  logic [31:0] rd_data [2];

  spi_flash_burst #(.ADDR_BITS(24), .CLK_DIV(1), .FAST_READ(1'b0), .MAX_LEN(8), .CS_HIGH_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_word_addr(req_word_addr[0]), .req_len(req_len[0]), .rd_valid(rd_valid[0]),
    .rd_data(rd_data[0]), .rd_last(rd_last[0]), .busy(busy[0]), .spi_clk(spi_clk[0]),
    .spi_cs_n(spi_cs_n[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0]));

  spi_flash_burst #(.ADDR_BITS(24), .CLK_DIV(3), .FAST_READ(1'b1), .MAX_LEN(8), .CS_HIGH_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_word_addr(req_word_addr[1]), .req_len(req_len[1]), .rd_valid(rd_valid[1]),
    .rd_data(rd_data[1]), .rd_last(rd_last[1]), .busy(busy[1]), .spi_clk(spi_clk[1]),
    .spi_cs_n(spi_cs_n[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1]));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem [512];
  int          hb [2] = '{32, 40};
  int          n [2] = '{0, 0};
  int          pulses [2] = '{0, 0};
  int          ones [2] = '{0, 0};
  int          sck_bad [2] = '{0, 0};
  int          falls [2] = '{0, 0};
  int          rise_c [2] = '{0, 0};
  int          gap_c [2] = '{0, 0};
  int          rd_n [2] = '{0, 0};
  logic [47:0] hdr [2];
  logic [47:0] hdr_cap [2];
  logic [1:0]  sck_prev = 2'b00;
  logic [1:0]  cs_prev = 2'b11;
  logic [31:0] rd_d [2][64];
  logic        rd_l [2][64];
  int          rd_c [2][64];
  int          md, midx;
  logic [47:0] msh;

  // Flash model and monitors, sampled on the falling clk edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (spi_cs_n[i]) begin
        if (!cs_prev[i]) rise_c[i] = cyc;
        if (spi_clk[i] && !sck_prev[i]) sck_bad[i]++;
        n[i] = 0;
        hdr[i] = '0;
        spi_miso[i] = 1'b0;
      end else begin
        if (cs_prev[i]) begin
          falls[i]++;
          gap_c[i] = cyc - rise_c[i];
        end
        if (spi_clk[i] && !sck_prev[i]) begin
          pulses[i]++;
          if (n[i] < hb[i]) hdr[i] = {hdr[i][46:0], spi_mosi[i]};
          else if (spi_mosi[i]) ones[i]++;
          n[i]++;
          if (n[i] == hb[i]) hdr_cap[i] = hdr[i];
        end
        if (n[i] >= hb[i]) begin
          md = n[i] - hb[i];
          msh = hdr[i] >> (hb[i] - 32);
          midx = (int'(msh[23:0]) + md / 8) % 512;
          spi_miso[i] = mem[midx][7 - (md % 8)];
        end else begin
          spi_miso[i] = 1'b0;
        end
      end
      if (rd_valid[i] && rd_n[i] < 64) begin
        rd_d[i][rd_n[i]] = rd_data[i];
        rd_l[i][rd_n[i]] = rd_last[i];
        rd_c[i][rd_n[i]] = cyc;
        rd_n[i]++;
      end
      sck_prev[i] = spi_clk[i];
      cs_prev[i] = spi_cs_n[i];
    end
  end

  task automatic start(input int i, input logic [21:0] wa, input logic [3:0] len, output int e0);
    int t = 0;
    while (!req_ready[i] && t < 2000) begin @(negedge clk); t++; end
    total++;
    if (req_ready[i] !== 1'b1) begin
      bad++;
      $display("FAIL start_ready inst=%0d got=%b want=1", i, req_ready[i]);
    end
    req_word_addr[i] = wa;
    req_len[i] = len;
    req_valid[i] = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    @(negedge clk);
    while (busy[i] && t < 5000) begin @(negedge clk); t++; end
    total++;
    if (busy[i] !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout inst=%0d busy=%b want=0", i, busy[i]);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({spi_cs_n[i], spi_clk[i], spi_mosi[i], rd_valid[i], rd_last[i], busy[i], req_ready[i]} !== 7'b1000001) begin
        bad++;
        $display("FAIL reset_ctrl inst=%0d got=%b want=1000001", i,
                 {spi_cs_n[i], spi_clk[i], spi_mosi[i], rd_valid[i], rd_last[i], busy[i], req_ready[i]});
      end
      total++;
      if (rd_data[i] !== 32'h0) begin
        bad++;
        $display("FAIL reset_data inst=%0d got=%h want=0", i, rd_data[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int e0, base;
    base = rd_n[0];
    start(0, 22'h40, 4'd4, e0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({spi_cs_n[0], spi_clk[0], rd_valid[0], req_ready[0], busy[0]} !== 5'b10010) begin
      bad++;
      $display("FAIL reset_mid got=%b want=10010", {spi_cs_n[0], spi_clk[0], rd_valid[0], req_ready[0], busy[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    total++;
    if (rd_n[0] - base != 0) begin
      bad++;
      $display("FAIL reset_mid_words got=%0d want=0", rd_n[0] - base);
    end
  endtask

  task automatic test_single;
    int e0, base;
    mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
    base = rd_n[0];
    start(0, 22'h40, 4'd1, e0);
    wait_idle(0);
    total++;
    if (hdr_cap[0][31:0] !== 32'h03000100) begin
      bad++;
      $display("FAIL single_mosi got=%h want=03000100", hdr_cap[0][31:0]);
    end
    total++;
    if (rd_n[0] - base != 1) begin
      bad++;
      $display("FAIL single_count got=%0d want=1", rd_n[0] - base);
    end else begin
      total++;
      if (rd_d[0][base] !== 32'h44332211 || rd_l[0][base] !== 1'b1) begin
        bad++;
        $display("FAIL single_data got=%h last=%b want=44332211 last=1", rd_d[0][base], rd_l[0][base]);
      end
      total++;
      if (rd_c[0][base] != e0 + 127) begin
        bad++;
        $display("FAIL single_time got=%0d want=%0d", rd_c[0][base], e0 + 127);
      end
    end
  endtask

  task automatic test_burst;
    int e0, base, p0, o0;
    logic [31:0] exp_w [4];
    exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    base = rd_n[0];
    p0 = pulses[0];
    o0 = ones[0];
    start(0, 22'h0, 4'd4, e0);
    wait_idle(0);
    total++;
    if (rd_n[0] - base != 4) begin
      bad++;
      $display("FAIL burst_count got=%0d want=4", rd_n[0] - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rd_d[0][base+k] !== exp_w[k] || rd_l[0][base+k] !== (k == 3) || rd_c[0][base+k] != e0 + 127 + 64 * k) begin
          bad++;
          $display("FAIL burst_word%0d got=%h last=%b t=%0d want=%h last=%b t=%0d", k, rd_d[0][base+k],
                   rd_l[0][base+k], rd_c[0][base+k], exp_w[k], (k == 3), e0 + 127 + 64 * k);
        end
      end
    end
    total++;
    if (pulses[0] - p0 != 160) begin
      bad++;
      $display("FAIL burst_sck got=%0d want=160", pulses[0] - p0);
    end
    total++;
    if (ones[0] - o0 != 0) begin
      bad++;
      $display("FAIL burst_mosi_data got=%0d want=0", ones[0] - o0);
    end
  endtask

  task automatic test_fast;
    int e0, base, p0;
    for (int k = 0; k < 8; k++) mem[256 + k] = 8'hA0 + 8'(k);
    base = rd_n[1];
    p0 = pulses[1];
    start(1, 22'h40, 4'd2, e0);
    wait_idle(1);
    total++;
    if (hdr_cap[1][39:0] !== 40'h0B00010000) begin
      bad++;
      $display("FAIL fast_mosi got=%h want=0b00010000", hdr_cap[1][39:0]);
    end
    total++;
    if (pulses[1] - p0 != 104) begin
      bad++;
      $display("FAIL fast_sck got=%0d want=104", pulses[1] - p0);
    end
    total++;
    if (rd_n[1] - base != 2) begin
      bad++;
      $display("FAIL fast_count got=%0d want=2", rd_n[1] - base);
    end else begin
      total++;
      if (rd_d[1][base] !== 32'hA3A2A1A0 || rd_d[1][base+1] !== 32'hA7A6A5A4 || rd_l[1][base+1] !== 1'b1) begin
        bad++;
        $display("FAIL fast_data got=%h %h want=a3a2a1a0 a7a6a5a4", rd_d[1][base], rd_d[1][base+1]);
      end
      total++;
      if (rd_c[1][base] != e0 + 429 || rd_c[1][base+1] != e0 + 621) begin
        bad++;
        $display("FAIL fast_time got=%0d %0d want=%0d %0d", rd_c[1][base], rd_c[1][base+1], e0 + 429, e0 + 621);
      end
    end
  endtask

  task automatic test_len_edges;
    int e0, base, f0;
    base = rd_n[0];
    start(0, 22'h10, 4'd0, e0);
    wait_idle(0);
    total++;
    if (rd_n[0] - base != 1 || rd_d[0][base] !== 32'h43424140 || rd_l[0][base] !== 1'b1) begin
      bad++;
      $display("FAIL len0 got=%0d words data=%h want=1 words data=43424140", rd_n[0] - base, rd_d[0][base]);
    end
    base = rd_n[0];
    f0 = falls[0];
    start(0, 22'h0, 4'd15, e0);
    repeat (20) @(negedge clk);
    req_word_addr[0] = 22'h80;
    req_len[0] = 4'd1;
    req_valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    req_valid[0] = 1'b0;
    wait_idle(0);
    total++;
    if (rd_n[0] - base != 8) begin
      bad++;
      $display("FAIL len15_count got=%0d want=8", rd_n[0] - base);
    end else begin
      total++;
      if (rd_d[0][base+7] !== 32'h1F1E1D1C || rd_l[0][base+7] !== 1'b1 || rd_l[0][base+6] !== 1'b0) begin
        bad++;
        $display("FAIL len15_last got=%h l7=%b l6=%b want=1f1e1d1c l7=1 l6=0",
                 rd_d[0][base+7], rd_l[0][base+7], rd_l[0][base+6]);
      end
    end
    total++;
    if (falls[0] - f0 != 1) begin
      bad++;
      $display("FAIL busy_ignore got=%0d bursts want=1", falls[0] - f0);
    end
  endtask

  task automatic test_back_to_back;
    int acc, t, base, f0;
    base = rd_n[0];
    f0 = falls[0];
    req_word_addr[0] = 22'h0;
    req_len[0] = 4'd1;
    req_valid[0] = 1'b1;
    acc = 0;
    t = 0;
    while (acc < 2 && t < 3000) begin
      if (req_ready[0]) acc++;
      @(negedge clk);
      t++;
    end
    req_valid[0] = 1'b0;
    wait_idle(0);
    total++;
    if (falls[0] - f0 != 2 || rd_n[0] - base != 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d bursts %0d words want=2 2", falls[0] - f0, rd_n[0] - base);
    end else begin
      total++;
      if (rd_d[0][base+1] !== 32'h03020100) begin
        bad++;
        $display("FAIL b2b_data got=%h want=03020100", rd_d[0][base+1]);
      end
    end
    total++;
    if (gap_c[0] < 2) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want>=2", gap_c[0]);
    end
    total++;
    if (sck_bad[0] != 0 || sck_bad[1] != 0) begin
      bad++;
      $display("FAIL sck_cs_high got=%0d %0d want=0 0", sck_bad[0], sck_bad[1]);
    end
  endtask

  initial begin
    req_valid = 2'b00;
    req_word_addr = '{22'h0, 22'h0};
    req_len = '{4'd0, 4'd0};
    for (int k = 0; k < 512; k++) mem[k] = 8'(k);
    test_reset;
    test_reset_mid;
    test_single;
    test_burst;
    test_fast;
    test_len_edges;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
